voice_player: RTL
=================

VOICE_PLAYER -- requirements
Module: voice_player

Interface
REQ-001 The block SHALL have parameter PHASE_WIDTH, default 22: the phase accumulator and step_size width.
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 10: the sine_addr width.
REQ-003 The block SHALL have parameter SAMPLE_WIDTH, default 16: the width of the signed sample_in and sample_out.
REQ-004 The ports SHALL be as follows:
- clk  in  1  single clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- play  in  1  high means run; low means freeze.
- load_new_note  in  1  one-cycle pulse from the song_reader new_note_* output.
- note  in  6  note index; sampled on load_new_note.
- duration  in  6  length in beats; sampled on load_new_note.
- beat  in  1  one-cycle beat strobe.
- generate_next_sample  in  1  one-cycle sample request from the codec side.
- freq_addr  out  6  latched note; drives the external frequency ROM.
- step_size  in  PHASE_WIDTH  combinational ROM reply for freq_addr.
- sine_addr  out  ADDR_WIDTH  top ADDR_WIDTH bits of the phase; drives the external sine ROM, which has a 1-cycle registered read.
- sample_in  in  SAMPLE_WIDTH  sine ROM data.
- sample_out  out  SAMPLE_WIDTH  current sample.
- new_sample_ready  out  1  one-cycle pulse; sample_out is valid.
- note_done  out  1  one-cycle pulse at note end; feeds the song_reader note_*_done input.
- busy  out  1  high while a note is active.

Function
REQ-005 The FSM SHALL have states IDLE, ACTIVE, FETCH and PRESENT, encoded in 2 bits.
REQ-006 On load_new_note in any state, the block SHALL latch note into freq_addr and duration into remain, clear phase to 0, and go to ACTIVE on the next cycle; load SHALL take priority over every other event.
REQ-007 In ACTIVE, when generate_next_sample=1 and play=1, the block SHALL set phase to (phase + step_size) mod 2^PHASE_WIDTH and go to FETCH.
REQ-008 FETCH SHALL always go to PRESENT after one cycle; it covers the ROM latency.
REQ-009 In PRESENT, the block SHALL register sample_in into sample_out, pulse new_sample_ready for one cycle, and return to ACTIVE. Latency from request to ready SHALL be exactly 3 cycles.
REQ-010 In IDLE, or when play=0 in ACTIVE, generate_next_sample SHALL drive sample_out to 0 and pulse new_sample_ready on the next cycle; phase SHALL NOT change.
REQ-011 While play=0, remain and phase SHALL hold; beat SHALL be ignored.
REQ-012 In ACTIVE, FETCH or PRESENT with play=1 and beat=1, remain SHALL decrement by 1.
REQ-013 When a decrement makes remain reach 0, the block SHALL pulse note_done for one cycle, go to IDLE, and set sample_out to 0 on the same edge.
REQ-014 If the note reaches its end while in FETCH or PRESENT, the pending sample SHALL be dropped and new_sample_ready SHALL NOT pulse.
REQ-015 duration=0 at load SHALL cause a note_done pulse on the cycle after load, with a return to IDLE and no samples produced.
REQ-016 beat and load_new_note in the same cycle: the load SHALL win and the beat SHALL be discarded.
REQ-017 A request arriving while in FETCH or PRESENT SHALL be ignored; no queuing.
REQ-018 busy SHALL be 1 in every state except IDLE.
REQ-019 sine_addr SHALL equal phase[PHASE_WIDTH-1 : PHASE_WIDTH-ADDR_WIDTH].
REQ-020 All outputs SHALL be registered, except sine_addr, which is a direct slice of the phase register.

Reset
REQ-021 When reset=0, the block SHALL asynchronously set state=IDLE, phase=0, remain=0, freq_addr=0, sample_out=0, new_sample_ready=0, note_done=0 and busy=0.
REQ-022 Reset asserted mid-note SHALL abort the note with no note_done pulse; the block SHALL resume on the first rising clk edge after reset deasserts.

Configuration
REQ-023 Macro VOICE_PLAYER_REST_EN SHALL control rest handling.
- When defined: note==0 at load SHALL be a rest. Beats count normally and note_done fires normally. sample_out SHALL be 0 for every request. phase SHALL stay 0.
- When undefined: note 0 SHALL be played like any other index.

Verification
REQ-024 Reset: hold reset=0 with random inputs -> all outputs 0; after release, state IDLE and busy=0.
REQ-025 Basic note: load note=6'd20, duration=6'd3, step_size=22'h001000, play=1, then issue 4 requests -> sine_addr 1,2,3,4; each new_sample_ready exactly 3 cycles after its request; note_done on the 3rd beat; then busy=0.
REQ-026 Pause: during duration 2, drop play for 5 beats -> remain holds, sample_out=0 for those requests; after play=1, 2 more beats -> note_done.
REQ-027 Wrap and collisions:
- step_size=22'h3FFFFF from phase 1 -> phase 0.
- load_new_note and beat in the same cycle -> remain equals the new duration.
- duration=0 -> note_done on the cycle after load.
REQ-028 Note ends mid-fetch: final beat during FETCH -> no new_sample_ready; sample_out=0; note_done pulses once.
REQ-029 With VOICE_PLAYER_REST_EN defined: note=0, duration=2 -> all samples 0 and note_done after 2 beats. Without the macro: same stimulus -> nonzero samples from sample_in.

Source files
------------

// File: rtl/voice_player.sv
// Single-voice note player: phase-accumulator stepping through an external sine ROM, beat-counted note length.
// Optional rest handling (note index 0 plays silence) is enabled with VOICE_PLAYER_REST_EN.
//
// state   | meaning
// IDLE    | no note; sample requests answered with 0
// ACTIVE  | note playing, waiting for a sample request
// FETCH   | phase advanced, sine ROM read in flight
// PRESENT | ROM data valid, captured into sample_out
module voice_player #(
    parameter int PHASE_WIDTH  = 22,
    parameter int ADDR_WIDTH   = 10,
    parameter int SAMPLE_WIDTH = 16
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           play,
    input  logic                           load_new_note,
    input  logic [5:0]                     note,
    input  logic [5:0]                     duration,
    input  logic                           beat,
    input  logic                           generate_next_sample,
    output logic [5:0]                     freq_addr,
    input  logic [PHASE_WIDTH-1:0]         step_size,
    output logic [ADDR_WIDTH-1:0]          sine_addr,
    input  logic signed [SAMPLE_WIDTH-1:0] sample_in,
    output logic signed [SAMPLE_WIDTH-1:0] sample_out,
    output logic                           new_sample_ready,
    output logic                           note_done,
    output logic                           busy
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACTIVE  = 2'd1,
        FETCH   = 2'd2,
        PRESENT = 2'd3
    } state_t;

    state_t                 r_state;
    logic [PHASE_WIDTH-1:0] r_phase;
    logic [5:0]             r_remain;

    logic                   w_rest;
    logic                   w_beat_dec;
    logic                   w_end;
    logic [PHASE_WIDTH-1:0] w_phase_next;

`ifdef VOICE_PLAYER_REST_EN
    logic r_rest;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rest <= 1'b0;
        end else if (load_new_note) begin
            r_rest <= (note == 6'd0);
        end
    end

    assign w_rest = r_rest;
`else
    assign w_rest = 1'b0;
`endif

    assign sine_addr    = r_phase[PHASE_WIDTH-1 -: ADDR_WIDTH];
    assign w_phase_next = w_rest ? r_phase : r_phase + step_size;
    assign w_beat_dec   = play && beat && (r_state != IDLE);
    // remain==0 outside IDLE only occurs right after a zero-duration load
    assign w_end        = (r_state != IDLE) &&
                          ((r_remain == 6'd0) || (w_beat_dec && (r_remain == 6'd1)));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state          <= IDLE;
            r_phase          <= '0;
            r_remain         <= '0;
            freq_addr        <= '0;
            sample_out       <= '0;
            new_sample_ready <= 1'b0;
            note_done        <= 1'b0;
            busy             <= 1'b0;
        end else begin
            new_sample_ready <= 1'b0;
            note_done        <= 1'b0;
            if (load_new_note) begin
                freq_addr <= note;
                r_remain  <= duration;
                r_phase   <= '0;
                r_state   <= ACTIVE;
                busy      <= 1'b1;
            end else if (w_end) begin
                // any sample still in FETCH/PRESENT is dropped here
                r_remain   <= '0;
                note_done  <= 1'b1;
                sample_out <= '0;
                r_state    <= IDLE;
                busy       <= 1'b0;
            end else begin
                if (w_beat_dec) begin
                    r_remain <= r_remain - 6'd1;
                end
                case (r_state)
                    IDLE: begin
                        if (generate_next_sample) begin
                            sample_out       <= '0;
                            new_sample_ready <= 1'b1;
                        end
                    end
                    ACTIVE: begin
                        if (generate_next_sample) begin
                            if (play) begin
                                r_phase <= w_phase_next;
                                r_state <= FETCH;
                            end else begin
                                sample_out       <= '0;
                                new_sample_ready <= 1'b1;
                            end
                        end
                    end
                    FETCH: begin
                        r_state <= PRESENT;
                    end
                    PRESENT: begin
                        sample_out       <= w_rest ? '0 : sample_in;
                        new_sample_ready <= 1'b1;
                        r_state          <= ACTIVE;
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

endmodule
